// File: rtl/monta_senha_pkg.sv
// Shared types and key codes for the password entry path.
// Holds the packed entry buffer type used between collector and verifier.
package monta_senha_pkg;

  localparam int NUM_DIG = 20;
  localparam int CNT_W   = 5;

  localparam logic [3:0] KEY_CLEAR   = 4'hA;
  localparam logic [3:0] KEY_CONFIRM = 4'hB;
  localparam logic [3:0] DIG_EMPTY   = 4'hF;

  // digits[0] is the oldest digit and sits in the least significant nibble
  typedef struct packed {
    logic [NUM_DIG-1:0][3:0] digits;
  } senhaPac_t;

  localparam senhaPac_t SENHA_VAZIA = senhaPac_t'({NUM_DIG{DIG_EMPTY}});

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/temporizador_inativo.sv
// Saturating up/down counter with clear, load, enable and terminal-count flag.
// Terminal value is MAX_CYC-1 counting up or 0 counting down; it never wraps.
module temporizador_inativo #(
  parameter int MAX_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic [((MAX_CYC > 1) ? $clog2(MAX_CYC) : 1)-1:0] load_val,
  input  logic en,
  input  logic down,
  output logic tc
);

  localparam int W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [W-1:0] TERM = W'(MAX_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !tc) begin
      cnt <= down ? (cnt - W'(1)) : (cnt + W'(1));
    end
  end

  always_comb begin
    tc = down ? (cnt == '0) : (cnt == TERM);
  end

endmodule

// File: rtl/monta_senha.sv
// Collects keypad digits into a 20-digit entry, hands it to the verifier and reports the outcome.
// Keys arriving while an attempt is in flight are dropped; a silent verifier times out as a failure.
module monta_senha
  import monta_senha_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int RESP_CYC    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output senhaPac_t        senha_teste,
  output logic             valid_out,
  input  logic             verif_done,
  input  logic             verif_ok,
  output logic             busy,
  output logic [CNT_W-1:0] digit_count,
  output logic             result_valid,
  output logic             result_ok
);

  typedef enum logic [1:0] {COLETA, ENVIA, AGUARDA, RESULTADO} estado_t;

  localparam logic [CNT_W-1:0] MAX_DIG = CNT_W'(NUM_DIG);
  localparam int INAT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RESP_W = (RESP_CYC > 1) ? $clog2(RESP_CYC) : 1;

  estado_t          state, state_nxt;
  senhaPac_t        senha_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ok_q;

  logic coleta, key_dig, key_clr, key_cnf, key_aceita;
  logic inat_clr, inat_en, inat_tc, timeout;
  logic resp_clr, resp_en, resp_tc;

  always_comb begin
    coleta     = (state == COLETA);
    key_dig    = coleta && key_valid && is_digit(key_code);
    key_clr    = coleta && key_valid && (key_code == KEY_CLEAR);
    key_cnf    = coleta && key_valid && (key_code == KEY_CONFIRM) && (cnt_q != '0);
    key_aceita = key_dig || key_clr || key_cnf;
    // a key in the same cycle as the terminal count keeps the entry alive
    timeout    = coleta && (cnt_q != '0) && inat_tc && !key_aceita;
    inat_en    = coleta && (cnt_q != '0);
    inat_clr   = !inat_en || key_aceita || timeout;
    resp_en    = (state == AGUARDA);
    resp_clr   = !resp_en;
  end

  temporizador_inativo #(.MAX_CYC(TIMEOUT_CYC)) u_tmr_inat (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (inat_clr),
    .load     (1'b0),
    .load_val ({INAT_W{1'b0}}),
    .en       (inat_en),
    .down     (1'b0),
    .tc       (inat_tc)
  );

  temporizador_inativo #(.MAX_CYC(RESP_CYC)) u_tmr_resp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (resp_clr),
    .load     (1'b0),
    .load_val ({RESP_W{1'b0}}),
    .en       (resp_en),
    .down     (1'b0),
    .tc       (resp_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLETA;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLETA:    if (key_cnf) state_nxt = ENVIA;
      ENVIA:     state_nxt = AGUARDA;
      AGUARDA:   if (verif_done || resp_tc) state_nxt = RESULTADO;
      RESULTADO: state_nxt = COLETA;
      default:   state_nxt = COLETA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      senha_q <= SENHA_VAZIA;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      case (state)
        COLETA: begin
          if (key_clr || timeout) begin
            senha_q <= SENHA_VAZIA;
            cnt_q   <= '0;
          end else if (key_dig) begin
            if (cnt_q < MAX_DIG) begin
              senha_q.digits[cnt_q] <= key_code;
              cnt_q                 <= cnt_q + CNT_W'(1);
            end else begin
              // full buffer: drop the oldest digit, newest goes to the top slot
              for (int i = 0; i < NUM_DIG - 1; i++) begin
                senha_q.digits[i] <= senha_q.digits[i+1];
              end
              senha_q.digits[NUM_DIG-1] <= key_code;
            end
          end
        end
        AGUARDA: begin
          if (verif_done)   ok_q <= verif_ok;
          else if (resp_tc) ok_q <= 1'b0;
        end
        RESULTADO: begin
          senha_q <= SENHA_VAZIA;
          cnt_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_out    = (state == ENVIA);
    busy         = (state != COLETA);
    result_valid = (state == RESULTADO);
    result_ok    = (state == RESULTADO) && ok_q;
    senha_teste  = senha_q;
    digit_count  = cnt_q;
  end

endmodule

// File: doc/monta_senha.md
MONTA_SENHA -- requirements
Module: monta_senha

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000: idle cycles after the last key before a partial entry is discarded.
REQ-002 Parameter RESP_CYC, default 64: maximum cycles to wait for verif_done before the attempt is forced to fail.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 key_valid  in  1  one-cycle pulse; key_code is valid in that cycle.
REQ-006 key_code  in  4  values 0-9 are digits; 4'hA is CLEAR ('*'); 4'hB is CONFIRM ('#'); all other codes are ignored.
REQ-007 senha_teste  out  senhaPac_t  packed 20-digit entry; digits[0] holds the oldest digit; unused slots hold 4'hF.
REQ-008 valid_out  out  1  one-cycle pulse; senha_teste is ready for the verifier.
REQ-009 verif_done  in  1  verifier completion strobe.
REQ-010 verif_ok  in  1  verifier result; sampled only when verif_done=1.
REQ-011 busy  out  1  high from the first valid_out cycle until result_valid, inclusive.
REQ-012 digit_count  out  5  number of digits stored, 0-20.
REQ-013 result_valid  out  1  one-cycle pulse marking the attempt outcome.
REQ-014 result_ok  out  1  attempt outcome; meaningful only when result_valid=1.

Function
REQ-015 State machine shall have four states: COLETA, ENVIA, AGUARDA, RESULTADO.
REQ-016 COLETA, digit key with digit_count<20: digits[digit_count] <= key_code; count += 1.
REQ-017 COLETA, digit key with count=20: buffer shifts toward index 0 (digits[i] <= digits[i+1]); digits[19] <= key_code; count stays 20.
REQ-018 COLETA, CLEAR key: all digits become 4'hF and count becomes 0 on the next edge.
REQ-019 COLETA, CONFIRM key with count>=1: next state ENVIA. CONFIRM with count=0 is ignored.
REQ-020 ENVIA lasts exactly one cycle: valid_out=1, then the FSM moves to AGUARDA. valid_out shall rise on the cycle after the edge that samples CONFIRM.
REQ-021 senha_teste shall remain stable from ENVIA until RESULTADO ends.
REQ-022 AGUARDA, verif_done=1: capture verif_ok and go to RESULTADO.
REQ-023 AGUARDA, RESP_CYC cycles without verif_done: result is 0 and the FSM goes to RESULTADO.
REQ-024 RESULTADO lasts one cycle: result_valid=1 and result_ok shows the captured value. The buffer is cleared to all 4'hF, count becomes 0, and the FSM returns to COLETA.
REQ-025 key_valid outside COLETA shall be ignored and dropped, not queued.
REQ-026 verif_done outside AGUARDA shall be ignored.
REQ-027 Inactivity timer: runs in COLETA while count>0 and restarts on every accepted key. When it reaches TIMEOUT_CYC-1, the buffer and count are cleared; result_valid is not asserted.
REQ-028 In COLETA with count=0, the timer shall be held at 0.
REQ-029 Ignored key codes shall not restart the inactivity timer.
REQ-030 Counters shall be sized with $clog2 of their parameter; they must never wrap, and each stops at its terminal value.

Reset
REQ-031 rst_n=0 shall asynchronously force the following, regardless of current state (including AGUARDA mid-attempt):
- state COLETA
- all digits 4'hF
- digit_count 0
- both timers 0
- valid_out, busy, result_valid, result_ok all 0
REQ-032 After reset release, the first clk edge may accept a key.

Structure
REQ-033 senhaPac_t and the key constants (KEY_CLEAR=4'hA, KEY_CONFIRM=4'hB, DIG_EMPTY=4'hF) shall live in the shared package. The state enum stays local to the module.
REQ-034 One sub-module, temporizador_inativo, shall implement a loadable down/up counter with clear, enable and terminal-count flag. It shall be instantiated twice: once for TIMEOUT_CYC and once for RESP_CYC.

Verification
REQ-035 Keys 1,2,3,4,CONFIRM -> valid_out one cycle after CONFIRM is sampled; senha_teste digits[0..3]=1,2,3,4 and digits[4..19]=F. Then verif_done=1 with verif_ok=1 -> result_valid=1 and result_ok=1 on the next cycle; count returns to 0.
REQ-036 22 digit keys 0..9,0..9,7,8, then CONFIRM -> digits[0..19]=2..9,0..9,7,8 and count=20.
REQ-037 Keys 5,5,CLEAR,CONFIRM -> no valid_out; count=0; all digits F.
REQ-038 With TIMEOUT_CYC=16: key 9, then no keys for 16 cycles -> buffer cleared, count=0, no result_valid.
REQ-039 With RESP_CYC=8: keys 1,2,3,4,CONFIRM, no verif_done -> result_valid with result_ok=0 exactly 8 cycles after entering AGUARDA. A key 7 pressed during AGUARDA does not appear in the buffer afterward.
REQ-040 rst_n pulsed low during AGUARDA -> busy=0 and count=0 immediately. A verif_done=1 after reset produces no result_valid.
